spi_mem_arbiter: RTL and testbench

Shares the single external SPI SRAM between the CPU memory port and the debug port. It accepts word requests from either requester and arbitrates round-robin between them. For each granted request it runs one complete SPI READ (0x03) or WRITE (0x02) transaction on the memory pins, then returns read data with a one-cycle acknowledge. It sits between the CPU core / debug SPI slave and the top-level `mem_*` pins.

---
 rtl/spi_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_spi_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI SRAM between the CPU and debug ports.
// Each grant runs a 40-bit READ/WRITE frame (mode 0) and returns a one-cycle ack.
module spi_mem_arbiter #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [14:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_rdata_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [14:0] dbg_addr_i,
  input  logic [15:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [15:0] dbg_rdata_o,
  output logic        mem_csb_o,
  output logic        mem_sclk_o,
  output logic        mem_out_o,
  input  logic        mem_in_i,
  output logic        busy_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DESEL} state_t;
  typedef enum logic {PORT_CPU, PORT_DBG} port_t;

  state_t        state;
  port_t         gnt;
  port_t         last;
  logic          we_l;
  logic [39:0]   sr;
  logic [15:0]   rx;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic          pick_dbg;
  logic [39:0]   frame;

  // Debug wins only when alone or when the CPU was served last.
  always_comb begin
    pick_dbg = dbg_req_i && (!cpu_req_i || (last == PORT_CPU));
    if (pick_dbg)
      frame = {(dbg_we_i ? 8'h02 : 8'h03), dbg_addr_i, 1'b0,
               (dbg_we_i ? dbg_wdata_i : 16'h0000)};
    else
      frame = {(cpu_we_i ? 8'h02 : 8'h03), cpu_addr_i, 1'b0,
               (cpu_we_i ? cpu_wdata_i : 16'h0000)};
  end

  // MOSI is the shift register MSB; 40 shifts leave it zero for DESEL/IDLE.
  assign mem_out_o = sr[39];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= PORT_CPU;
      last        <= PORT_DBG;
      we_l        <= 1'b0;
      sr          <= '0;
      rx          <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      mem_csb_o   <= 1'b1;
      mem_sclk_o  <= 1'b0;
      busy_o      <= 1'b0;
      cpu_ack_o   <= 1'b0;
      dbg_ack_o   <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
    end else begin
      cpu_ack_o <= 1'b0;
      dbg_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_i || dbg_req_i) begin
            gnt        <= pick_dbg ? PORT_DBG : PORT_CPU;
            last       <= pick_dbg ? PORT_DBG : PORT_CPU;
            we_l       <= pick_dbg ? dbg_we_i : cpu_we_i;
            sr         <= frame;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            mem_csb_o  <= 1'b0;
            mem_sclk_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!mem_sclk_o) begin
              mem_sclk_o <= 1'b1;
            end else begin
              mem_sclk_o <= 1'b0;
              rx         <= {rx[14:0], mem_in_i};
              sr         <= {sr[38:0], 1'b0};
              if (bit_cnt == 6'd39) begin
                mem_csb_o <= 1'b1;
                state     <= DESEL;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DESEL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            busy_o  <= 1'b0;
            state   <= IDLE;
            if (gnt == PORT_CPU) begin
              cpu_ack_o <= 1'b1;
              if (!we_l) cpu_rdata_o <= rx;
            end else begin
              dbg_ack_o <= 1'b1;
              if (!we_l) dbg_rdata_o <= rx;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: CLK_DIV=1 instance for the vector table,
// contention and reset-abort cases, CLK_DIV=3 instance for slow-clock timing.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [14:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic        csb, sclk, mosi, busy;
  logic        miso = 1'b0;

  logic        b_cpu_req = 1'b0, b_cpu_we = 1'b0;
  logic [14:0] b_cpu_addr = '0;
  logic [15:0] b_cpu_wdata = '0;
  logic        b_cpu_ack;
  logic [15:0] b_cpu_rdata;
  logic        b_dbg_req = 1'b0, b_dbg_we = 1'b0;
  logic [14:0] b_dbg_addr = '0;
  logic [15:0] b_dbg_wdata = '0;
  logic        b_dbg_ack;
  logic [15:0] b_dbg_rdata;
  logic        b_csb, b_sclk, b_mosi, b_busy;

  spi_mem_arbiter #(.CLK_DIV(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
    .mem_csb_o(csb), .mem_sclk_o(sclk), .mem_out_o(mosi), .mem_in_i(miso),
    .busy_o(busy)
  );

  spi_mem_arbiter #(.CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr),
    .cpu_wdata_i(b_cpu_wdata), .cpu_ack_o(b_cpu_ack), .cpu_rdata_o(b_cpu_rdata),
    .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we), .dbg_addr_i(b_dbg_addr),
    .dbg_wdata_i(b_dbg_wdata), .dbg_ack_o(b_dbg_ack), .dbg_rdata_o(b_dbg_rdata),
    .mem_csb_o(b_csb), .mem_sclk_o(b_sclk), .mem_out_o(b_mosi), .mem_in_i(miso),
    .busy_o(b_busy)
  );

  logic msel = 1'b0;
  logic csb_m, sclk_m, mosi_m, busy_m;
  assign csb_m  = msel ? b_csb  : csb;
  assign sclk_m = msel ? b_sclk : sclk;
  assign mosi_m = msel ? b_mosi : mosi;
  assign busy_m = msel ? b_busy : busy;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    logic [39:0] mosi;
    logic [15:0] cpu_rd;
    logic [15:0] dbg_rd;
  } vec_t;

  vec_t vecs[5];

  int          r_ack_t, r_rise_t, r_nacks, r_oacks, r_terr;
  logic [39:0] r_mosi;
  logic        r_csb0, r_busy0, r_busy_end;

  // Runs one single-requester transaction, acting as the SPI SRAM: MISO is
  // updated after each SCLK rise so it is stable at the sampling fall.
  task automatic run_txn(input bit sel, input bit port, input bit we,
                         input logic [14:0] addr, input logic [15:0] wdata,
                         input logic [15:0] mdata, input int cd);
    int   t, nrise, limit;
    logic pcsb, psclk, pa, oa;
    msel = sel;
    if (sel) begin
      b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata; b_cpu_req = 1'b1;
    end else if (port) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    r_ack_t = -1; r_rise_t = -1; r_nacks = 0; r_oacks = 0; r_terr = 0;
    r_mosi = '0; r_csb0 = 1'b1; r_busy0 = 1'b0;
    nrise = 0; miso = 1'b0; pcsb = 1'b1; psclk = 1'b0;
    limit = 90 * cd + 10;
    t = -1;
    while (t < limit && (r_ack_t < 0 || t < r_ack_t + 1)) begin
      @(posedge clk); #1;
      t++;
      if (t == 0) begin r_csb0 = csb_m; r_busy0 = busy_m; end
      if (csb_m && !pcsb) r_rise_t = t;
      if (sclk_m && !psclk) begin
        if (t != cd * (2 * nrise + 1)) r_terr++;
        r_mosi = {r_mosi[38:0], mosi_m};
        nrise++;
        miso = (nrise > 24) ? mdata[40 - nrise] : 1'b0;
      end
      if (!sclk_m && psclk && t != cd * 2 * nrise) r_terr++;
      pa = sel ? b_cpu_ack : (port ? dbg_ack : cpu_ack);
      oa = sel ? b_dbg_ack : (port ? cpu_ack : dbg_ack);
      if (pa) begin
        r_nacks++;
        if (r_ack_t < 0) begin
          r_ack_t = t;
          if (sel) b_cpu_req = 1'b0;
          else if (port) dbg_req = 1'b0;
          else cpu_req = 1'b0;
        end
      end
      if (oa) r_oacks++;
      pcsb = csb_m; psclk = sclk_m;
    end
    if (nrise != 40) r_terr++;
    r_busy_end = busy_m;
    msel = 1'b0;
  endtask

  initial begin
    int   order[3];
    int   n, cyc, run, gap_err, dup_err;
    logic pc, pd, pcs, ack_seen;

    vecs[0] = '{1'b0, 1'b0, 15'h0001, 16'h0000, 16'hBEEF, 40'h03_0002_0000, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 15'h7FFF, 16'h1234, 16'h0000, 40'h02_FFFE_1234, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 15'h1234, 16'h0000, 16'hA55A, 40'h03_2468_0000, 16'hBEEF, 16'hA55A};
    vecs[3] = '{1'b0, 1'b1, 15'h0000, 16'hFFFF, 16'h1111, 40'h02_0000_FFFF, 16'hBEEF, 16'hA55A};
    vecs[4] = '{1'b0, 1'b0, 15'h4000, 16'h0000, 16'h0001, 40'h03_8000_0000, 16'h0001, 16'hA55A};

    repeat (3) @(posedge clk);
    #1;
    check("rst_csb",   64'({csb, b_csb}), 64'h3);
    check("rst_sclk",  64'({sclk, b_sclk}), 64'h0);
    check("rst_mosi",  64'({mosi, b_mosi}), 64'h0);
    check("rst_acks",  64'({cpu_ack, dbg_ack, b_cpu_ack, b_dbg_ack}), 64'h0);
    check("rst_rdata", 64'({cpu_rdata, dbg_rdata}), 64'h0);
    check("rst_busy",  64'({busy, b_busy}), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata, 1);
      check($sformatf("v%0d_csb_fall", i), 64'(r_csb0), 64'h0);
      check($sformatf("v%0d_busy", i),     64'(r_busy0), 64'h1);
      check($sformatf("v%0d_ack_t", i),    64'(r_ack_t), 64'd81);
      check($sformatf("v%0d_csb_rise", i), 64'(r_rise_t), 64'd80);
      check($sformatf("v%0d_nacks", i),    64'(r_nacks), 64'd1);
      check($sformatf("v%0d_oacks", i),    64'(r_oacks), 64'd0);
      check($sformatf("v%0d_sclk", i),     64'(r_terr), 64'd0);
      check($sformatf("v%0d_mosi", i),     64'(r_mosi), 64'(vecs[i].mosi));
      check($sformatf("v%0d_cpu_rd", i),   64'(cpu_rdata), 64'(vecs[i].cpu_rd));
      check($sformatf("v%0d_dbg_rd", i),   64'(dbg_rdata), 64'(vecs[i].dbg_rd));
      check($sformatf("v%0d_idle", i),     64'(r_busy_end), 64'h0);
    end

    // Reset during bit 20 of a CPU read.
    cpu_we = 1'b0; cpu_addr = 15'h0003; cpu_req = 1'b1;
    repeat (42) @(posedge clk);
    #1;
    check("mid_sclk_high", 64'({sclk, busy, csb}), 64'h6);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pins", 64'({csb, sclk, mosi, busy}), 64'h8);
    ack_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cpu_ack || dbg_ack) ack_seen = 1'b1;
    end
    check("mid_no_ack", 64'(ack_seen), 64'h0);
    check("mid_rdata_clr", 64'(cpu_rdata), 64'h0);
    reset = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 15'h0003, 16'h0000, 16'h5A5A, 1);
    check("mid_ack_t", 64'(r_ack_t), 64'd81);
    check("mid_nacks", 64'(r_nacks), 64'd1);
    check("mid_sclk",  64'(r_terr), 64'd0);
    check("mid_mosi",  64'(r_mosi), 64'h03_0006_0000);
    check("mid_rdata", 64'(cpu_rdata), 64'h5A5A);

    // Contention: both requests held from reset.
    reset = 1'b1;
    cpu_we = 1'b0; cpu_addr = 15'h0010; cpu_req = 1'b1;
    dbg_we = 1'b1; dbg_addr = 15'h0020; dbg_wdata = 16'hCAFE; dbg_req = 1'b1;
    miso = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    order = '{default: 9};
    n = 0; cyc = 0; run = 0; gap_err = 0; dup_err = 0;
    pc = 1'b0; pd = 1'b0; pcs = 1'b1;
    while (n < 3 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack && dbg_ack) dup_err++;
      if ((cpu_ack && pc) || (dbg_ack && pd)) dup_err++;
      if (cpu_ack || dbg_ack) begin
        order[n] = dbg_ack ? 1 : 0;
        n++;
      end
      if (!csb && pcs && n > 0 && run < 2) gap_err++;
      run = csb ? run + 1 : 0;
      pc = cpu_ack; pd = dbg_ack; pcs = csb;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;
    check("cont_acks",  64'(n), 64'd3);
    check("cont_order", 64'({order[0][1:0], order[1][1:0], order[2][1:0]}), 64'b00_01_00);
    check("cont_cycles", 64'(cyc), 64'd246);
    check("cont_single", 64'(dup_err), 64'd0);
    check("cont_gap",   64'(gap_err), 64'd0);
    check("cont_clear", 64'({cpu_ack, dbg_ack, busy}), 64'h0);
    check("cont_dbg_rd", 64'(dbg_rdata), 64'h0);

    // Slow SPI clock instance.
    run_txn(1'b1, 1'b0, 1'b0, 15'h0055, 16'h0000, 16'hC3A5, 3);
    check("cd3_csb_fall", 64'(r_csb0), 64'h0);
    check("cd3_ack_t",    64'(r_ack_t), 64'd243);
    check("cd3_csb_rise", 64'(r_rise_t), 64'd240);
    check("cd3_nacks",    64'(r_nacks), 64'd1);
    check("cd3_sclk",     64'(r_terr), 64'd0);
    check("cd3_mosi",     64'(r_mosi), 64'h03_00AA_0000);
    check("cd3_rdata",    64'(b_cpu_rdata), 64'hC3A5);
    check("cd3_dbg_rd",   64'(b_dbg_rdata), 64'h0);
    check("cd3_idle",     64'(r_busy_end), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
